// File: rtl/ic_hc_dc_encoder.sv
// Luminance DC encoder: DPCM against the previous block's DC, category lookup through an
// external 1-cycle Huffman ROM, and emission of a right-aligned {code, amplitude} codeword.
module ic_hc_dc_encoder #(
  parameter int unsigned DC_W   = 11,
  parameter int unsigned CODE_W = 16,
  parameter int unsigned LEN_W  = 5,
  localparam int unsigned CatW  = $clog2(DC_W + 1),
  localparam int unsigned DiffW = DC_W + 1,
  localparam int unsigned OutW  = CODE_W + DC_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    restart_i,
  input  logic                    dc_valid_i,
  output logic                    dc_ready_o,
  input  logic [DC_W-1:0]         dc_data_i,
  output logic [CatW-1:0]         rom_addr_o,
  input  logic [LEN_W+CODE_W-1:0] rom_q_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [OutW-1:0]         out_bits_o,
  output logic [LEN_W-1:0]        out_len_o
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StOut} state_e;

  state_e             state_q, state_d;
  logic [DC_W-1:0]    pred_q, pred_d;
  logic [DiffW-1:0]   diff_q, diff_d;
  logic [CatW-1:0]    cat_q, cat_d;
  logic               dc_ready_q, dc_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OutW-1:0]    out_bits_q, out_bits_d;
  logic [LEN_W-1:0]   out_len_q, out_len_d;

  logic               dc_hs;
  logic [DC_W-1:0]    pred_eff;
  logic [DiffW-1:0]   diff_c;
  logic [DiffW-1:0]   mag_c;
  logic [CatW-1:0]    cat_c;

  logic [LEN_W-1:0]   rom_len;
  logic [CODE_W-1:0]  rom_code;
  logic [CODE_W-1:0]  code_m;
  logic [DC_W-1:0]    amp_raw;
  logic [DC_W-1:0]    amp_m;
  logic [OutW-1:0]    bits_c;
  logic [LEN_W-1:0]   len_c;

  assign dc_hs = dc_valid_i & dc_ready_q;

  // A restart coinciding with a handshake must clear the predictor before the difference.
  assign pred_eff = restart_i ? '0 : pred_q;
  assign diff_c   = {dc_data_i[DC_W-1], dc_data_i} - {pred_eff[DC_W-1], pred_eff};
  assign mag_c    = diff_c[DiffW-1] ? (~diff_c + DiffW'(1)) : diff_c;

  always_comb begin
    cat_c = '0;
    for (int i = 0; i < int'(DiffW); i++) begin
      if (mag_c[i]) cat_c = CatW'(i + 1);
    end
  end

  assign rom_len  = rom_q_i[LEN_W+CODE_W-1:CODE_W];
  assign rom_code = rom_q_i[CODE_W-1:0];
  assign code_m   = rom_code & ~({CODE_W{1'b1}} << rom_len);

  // Negative differences use one's complement: low bits of (diff - 1).
  assign amp_raw = diff_q[DC_W-1:0] - {{(DC_W-1){1'b0}}, diff_q[DiffW-1]};
  assign amp_m   = amp_raw & ~({DC_W{1'b1}} << cat_q);

  assign bits_c = ({{DC_W{1'b0}}, code_m} << cat_q) | {{CODE_W{1'b0}}, amp_m};
  assign len_c  = rom_len + LEN_W'(cat_q);

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    diff_d      = diff_q;
    cat_d       = cat_q;
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;
    out_len_d   = out_len_q;

    if (restart_i) pred_d = '0;

    case (state_q)
      StIdle: begin
        if (dc_hs) begin
          diff_d  = diff_c;
          cat_d   = cat_c;
          pred_d  = dc_data_i;
          state_d = StAddr;
        end
      end
      StAddr: state_d = StData;
      StData: begin
        out_bits_d  = bits_c;
        out_len_d   = len_c;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    dc_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pred_q      <= '0;
      diff_q      <= '0;
      cat_q       <= '0;
      dc_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      diff_q      <= diff_d;
      cat_q       <= cat_d;
      dc_ready_q  <= dc_ready_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_len_q   <= out_len_d;
    end
  end

  assign dc_ready_o  = dc_ready_q;
  assign rom_addr_o  = cat_q;
  assign out_valid_o = out_valid_q;
  assign out_bits_o  = out_bits_q;
  assign out_len_o   = out_len_q;

endmodule

// File: tb/tb_ic_hc_dc_encoder.sv
// Directed bench for ic_hc_dc_encoder with a JPEG DC-luminance ROM model (1-cycle read).
module tb_ic_hc_dc_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        restart = 1'b0;
  logic        dc_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] dc_data = '0;
  logic        dc_ready;
  logic [3:0]  rom_addr;
  logic [20:0] rom_q = '0;
  logic        out_valid;
  logic [26:0] out_bits;
  logic [4:0]  out_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ic_hc_dc_encoder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .restart_i  (restart),
    .dc_valid_i (dc_valid),
    .dc_ready_o (dc_ready),
    .dc_data_i  (dc_data),
    .rom_addr_o (rom_addr),
    .rom_q_i    (rom_q),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_bits_o (out_bits),
    .out_len_o  (out_len)
  );

  // Standard table; some entries carry junk above the code length to exercise masking.
  function automatic logic [20:0] rom_word(input logic [3:0] a);
    case (a)
      4'd0:    return {5'd2, 16'h0000};
      4'd1:    return {5'd3, 16'h0002};
      4'd2:    return {5'd3, 16'h0003};
      4'd3:    return {5'd3, 16'hFFF4};
      4'd4:    return {5'd3, 16'h0005};
      4'd5:    return {5'd3, 16'h0006};
      4'd6:    return {5'd4, 16'h000E};
      4'd7:    return {5'd5, 16'hA51E};
      4'd8:    return {5'd6, 16'h003E};
      4'd9:    return {5'd7, 16'h007E};
      4'd10:   return {5'd8, 16'h00FE};
      4'd11:   return {5'd9, 16'h01FE};
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) rom_q <= rom_word(rom_addr);

  task automatic send_dc(input logic [10:0] d, input logic rs, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dc_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      dc_valid = 1'b1;
      dc_data  = d;
      restart  = rs;
      @(posedge clk);
      #1;
      dc_valid = 1'b0;
      restart  = 1'b0;
    end
  endtask

  task automatic get_out(output logic [26:0] b, output logic [4:0] l, output int lat,
                         output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    b = out_bits;
    l = out_len;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (dc_ready !== 1'b0) begin fails++; $display("FAIL reset_dc_ready got %b want 0", dc_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++;
    if (out_bits !== 27'd0) begin fails++; $display("FAIL reset_out_bits got %h want 0", out_bits); end
    tests++;
    if (out_len !== 5'd0) begin fails++; $display("FAIL reset_out_len got %0d want 0", out_len); end
    tests++;
    if (rom_addr !== 4'd0) begin fails++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (dc_ready !== 1'b0) begin fails++; $display("FAIL release_ready_early got %b want 0", dc_ready); end
    @(posedge clk);
    #1;
    tests++;
    if (dc_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %b want 1", dc_ready); end
  endtask

  task automatic test_first;
    bit ok;
    logic [26:0] b;
    logic [4:0] l;
    int lat;
    send_dc(11'd5, 1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL first_handshake got timeout want dc_ready"); end
    tests++;
    if (rom_addr !== 4'd3) begin fails++; $display("FAIL first_rom_addr got %0d want 3", rom_addr); end
    get_out(b, l, lat, ok);
    tests++;
    if (!ok || lat != 3) begin fails++; $display("FAIL first_latency got %0d want 3", lat); end
    tests++;
    if (b !== 27'b100101) begin fails++; $display("FAIL first_bits got %b want 100101", b); end
    tests++;
    if (l !== 5'd6) begin fails++; $display("FAIL first_len got %0d want 6", l); end
  endtask

  task automatic test_sequence;
    bit ok;
    logic [26:0] b;
    logic [4:0] l;
    int lat;
    send_dc(11'd3, 1'b0, ok);
    get_out(b, l, lat, ok);
    tests++;
    if (!ok || b !== 27'b01101) begin fails++; $display("FAIL neg_diff_bits got %b want 01101", b); end
    tests++;
    if (l !== 5'd5) begin fails++; $display("FAIL neg_diff_len got %0d want 5", l); end
    send_dc(11'd3, 1'b0, ok);
    get_out(b, l, lat, ok);
    tests++;
    if (!ok || b !== 27'd0) begin fails++; $display("FAIL zero_diff_bits got %b want 00", b); end
    tests++;
    if (l !== 5'd2) begin fails++; $display("FAIL zero_diff_len got %0d want 2", l); end
  endtask

  task automatic test_extremes;
    bit ok;
    logic [26:0] b;
    logic [4:0] l;
    int lat;
    send_dc(11'd1023, 1'b0, ok);
    get_out(b, l, lat, ok);
    send_dc(11'h400, 1'b0, ok);
    tests++;
    if (rom_addr !== 4'd11) begin fails++; $display("FAIL max_cat got %0d want 11", rom_addr); end
    get_out(b, l, lat, ok);
    tests++;
    if (!ok || b !== {9'b111111110, 11'b0}) begin
      fails++;
      $display("FAIL max_diff_bits got %h want %h", b, {9'b111111110, 11'b0});
    end
    tests++;
    if (l !== 5'd20) begin fails++; $display("FAIL max_diff_len got %0d want 20", l); end
  endtask

  task automatic test_backpressure;
    bit ok;
    // pred is -1024; -1000 gives diff 24: cat 5, code 110, amp 11000
    send_dc(11'h418, 1'b0, ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_valid got timeout want out_valid"); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_bits !== 27'b11011000 || out_len !== 5'd8 ||
          dc_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d got v=%b bits=%b len=%0d rdy=%b want 1 11011000 8 0",
                 i, out_valid, out_bits, out_len, dc_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_single got %b want 0", out_valid); end
    tests++;
    if (dc_ready !== 1'b1) begin fails++; $display("FAIL bp_ready got %b want 1", dc_ready); end
  endtask

  task automatic test_restart;
    bit ok;
    logic [26:0] b;
    logic [4:0] l;
    int lat;
    send_dc(11'd100, 1'b0, ok);
    get_out(b, l, lat, ok);
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    send_dc(11'd100, 1'b0, ok);
    get_out(b, l, lat, ok);
    tests++;
    if (!ok || b !== 27'b111101100100) begin
      fails++;
      $display("FAIL restart_alone_bits got %b want 111101100100", b);
    end
    tests++;
    if (l !== 5'd12) begin fails++; $display("FAIL restart_alone_len got %0d want 12", l); end
    send_dc(11'd100, 1'b1, ok);
    get_out(b, l, lat, ok);
    tests++;
    if (!ok || b !== 27'b111101100100) begin
      fails++;
      $display("FAIL restart_coincident_bits got %b want 111101100100", b);
    end
    tests++;
    if (l !== 5'd12) begin fails++; $display("FAIL restart_coincident_len got %0d want 12", l); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int bad;
    logic [26:0] b;
    logic [4:0] l;
    int lat;
    send_dc(11'd7, 1'b0, ok);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (out_valid !== 1'b0) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL midreset_valid got %0d high samples want 0", bad); end
    send_dc(11'd1, 1'b0, ok);
    get_out(b, l, lat, ok);
    tests++;
    if (!ok || b !== 27'b0101) begin fails++; $display("FAIL midreset_bits got %b want 0101", b); end
    tests++;
    if (l !== 5'd4) begin fails++; $display("FAIL midreset_len got %0d want 4", l); end
  endtask

  initial begin
    test_reset();
    test_first();
    test_sequence();
    test_extremes();
    test_backpressure();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
